// File: rtl/execute_multiply_pkg.sv
// Shared types and helpers for the iterative execute-stage multiplier.
// Operation codes sit beside the divider op codes in the decode tables.
package execute_multiply_pkg;

   localparam int REGSZ = 32;

   typedef enum logic [1:0] {
      MUL_LW  = 2'd0,
      MUL_HW  = 2'd1,
      MUL_HWU = 2'd2,
      MUL_LWU = 2'd3
   } mul_op_e;

   // |0x80000000| wraps back to 0x80000000, which is the correct unsigned magnitude
   function automatic logic [REGSZ-1:0] abs32(input logic [REGSZ-1:0] v);
      return v[REGSZ-1] ? (~v + 32'd1) : v;
   endfunction

endpackage

// File: rtl/execute_multiply_if.sv
// Request/result bundle between the execute stage and the iterative multiplier.
// Handshake matches the divider: enable held until done, dropping it cancels.
interface execute_multiply_if;
   import execute_multiply_pkg::*;

   logic             enable;
   logic [1:0]       mul_op;
   logic [REGSZ-1:0] in_a;
   logic [REGSZ-1:0] in_b;
   logic             done;
   logic [REGSZ-1:0] out;
   logic             ov;

   modport master (output enable, mul_op, in_a, in_b, input done, out, ov);
   modport slave  (input enable, mul_op, in_a, in_b, output done, out, ov);

endinterface

// File: rtl/execute_multiply.sv
// Iterative 32x32 multiplier: sign-magnitude shift-add, one bit per cycle,
// then a fix-up cycle that restores the sign and selects the result word.
//
// state | meaning
// IDLE  | waiting for enable; operands captured on the accepting edge
// BUSY  | 32 shift-add iterations over the multiplier bits, LSB first
// FIX   | negate 64-bit product if needed, select word, compute ov
// DONE  | result valid; waits for enable to drop
module execute_multiply
   import execute_multiply_pkg::*;
#(
   parameter bit EARLY_OUT = 1'b1
) (
   input  logic clk,
   input  logic reset_n,
   execute_multiply_if.slave mif
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_e;

   state_e           r_state, w_state_nxt;
   mul_op_e          r_op, w_op_nxt;
   logic [REGSZ-1:0] r_a, w_a_nxt;
   logic [REGSZ-1:0] r_b, w_b_nxt;
   logic [63:0]      r_p, w_p_nxt;
   logic             r_neg, w_neg_nxt;
   logic [4:0]       r_cnt, w_cnt_nxt;
   logic [REGSZ-1:0] r_out, w_out_nxt;
   logic             r_ov, w_ov_nxt;

   logic [32:0]      w_sum;
   logic [63:0]      w_p_signed;
   logic             w_is_signed;
   logic             w_zero_opnd;

   assign w_sum       = {1'b0, r_p[63:32]} + (r_b[0] ? {1'b0, r_a} : 33'd0);
   assign w_p_signed  = r_neg ? (~r_p + 64'd1) : r_p;
   assign w_is_signed = (mif.mul_op == MUL_LW) || (mif.mul_op == MUL_HW);
   assign w_zero_opnd = (mif.in_a == '0) || (mif.in_b == '0);

   always_comb begin
      w_state_nxt = r_state;
      w_op_nxt    = r_op;
      w_a_nxt     = r_a;
      w_b_nxt     = r_b;
      w_p_nxt     = r_p;
      w_neg_nxt   = r_neg;
      w_cnt_nxt   = r_cnt;
      w_out_nxt   = r_out;
      w_ov_nxt    = r_ov;
      case (r_state)
         S_IDLE: begin
            if (mif.enable) begin
               w_op_nxt  = mul_op_e'(mif.mul_op);
               w_a_nxt   = w_is_signed ? abs32(mif.in_a) : mif.in_a;
               w_b_nxt   = w_is_signed ? abs32(mif.in_b) : mif.in_b;
               w_neg_nxt = w_is_signed && (mif.in_a[REGSZ-1] ^ mif.in_b[REGSZ-1]);
               w_p_nxt   = '0;
               w_cnt_nxt = 5'd31;
               w_state_nxt = S_BUSY;
               if (EARLY_OUT && w_zero_opnd) begin
                  w_out_nxt   = '0;
                  w_ov_nxt    = 1'b0;
                  w_state_nxt = S_DONE;
               end
            end
         end
         S_BUSY: begin
            if (!mif.enable) begin
               w_state_nxt = S_IDLE;
            end else begin
               // carry out of the add lands in bit 63 after the shift
               w_p_nxt   = {w_sum, r_p[31:1]};
               w_b_nxt   = {1'b0, r_b[REGSZ-1:1]};
               w_cnt_nxt = r_cnt - 5'd1;
               if (r_cnt == 5'd0)
                  w_state_nxt = S_FIX;
            end
         end
         S_FIX: begin
            if (!mif.enable) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_out_nxt = ((r_op == MUL_LW) || (r_op == MUL_LWU)) ?
                           w_p_signed[31:0] : w_p_signed[63:32];
               w_ov_nxt  = (r_op == MUL_LW) &&
                           !((&w_p_signed[63:31]) || (~|w_p_signed[63:31]));
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            if (!mif.enable)
               w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
         r_op    <= MUL_LW;
         r_a     <= '0;
         r_b     <= '0;
         r_p     <= '0;
         r_neg   <= 1'b0;
         r_cnt   <= '0;
         r_out   <= '0;
         r_ov    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_op    <= w_op_nxt;
         r_a     <= w_a_nxt;
         r_b     <= w_b_nxt;
         r_p     <= w_p_nxt;
         r_neg   <= w_neg_nxt;
         r_cnt   <= w_cnt_nxt;
         r_out   <= w_out_nxt;
         r_ov    <= w_ov_nxt;
      end
   end

   assign mif.done = (r_state == S_DONE);
   assign mif.out  = r_out;
   assign mif.ov   = r_ov;

endmodule

// File: tb/tb_execute_multiply.sv
// Directed-vector bench for execute_multiply; expected values are hand-computed.
// A second instance with EARLY_OUT=0 covers the no-shortcut zero-operand path.
module tb_execute_multiply;
   import execute_multiply_pkg::*;

   logic clk;
   logic reset_n;
   int   n_vec;
   int   n_miss;

   execute_multiply_if if0();
   execute_multiply_if if1();

   execute_multiply #(.EARLY_OUT(1'b1)) dut0 (.clk(clk), .reset_n(reset_n), .mif(if0));
   execute_multiply #(.EARLY_OUT(1'b0)) dut1 (.clk(clk), .reset_n(reset_n), .mif(if1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Request on dut0; lat = edges after the capture edge until done is seen.
   task automatic run0(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int lat);
      @(negedge clk);
      if0.mul_op = op; if0.in_a = a; if0.in_b = b; if0.enable = 1'b1;
      @(posedge clk); #1;
      if0.in_a = 32'hDEAD_BEEF; if0.in_b = 32'h0BAD_F00D;
      lat = 0;
      while (!if0.done && lat < 60) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic release0();
      @(negedge clk);
      if0.enable = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic op_chk(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] eo, input logic eov);
      int lat;
      run0(op, a, b, lat);
      chk({tag, "_lat"}, 64'(lat), 64'd33);
      chk({tag, "_out"}, 64'(if0.out), 64'(eo));
      chk({tag, "_ov"},  64'(if0.ov), 64'(eov));
      release0();
   endtask

   initial begin
      int lat;
      logic [31:0] held;
      logic seen;
      n_vec = 0; n_miss = 0;
      if0.enable = 0; if0.mul_op = 0; if0.in_a = 0; if0.in_b = 0;
      if1.enable = 0; if1.mul_op = 0; if1.in_a = 0; if1.in_b = 0;
      reset_n = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_done", 64'(if0.done), 64'd0);
      chk("rst_out",  64'(if0.out), 64'd0);
      chk("rst_ov",   64'(if0.ov), 64'd0);
      @(negedge clk); reset_n = 1;

      op_chk("hwu_ff", 2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
      op_chk("lw_min", 2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
      op_chk("hw_min", 2'd1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0);
      op_chk("lw_m2x3", 2'd0, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFA, 1'b0);
      op_chk("hw_m2x3", 2'd1, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 1'b0);
      op_chk("hwu_m2x3", 2'd2, 32'hFFFF_FFFE, 32'h0000_0003, 32'h0000_0002, 1'b0);
      op_chk("lwu_big", 2'd3, 32'h0001_0001, 32'h0001_0001, 32'h0002_0001, 1'b0);
      op_chk("lw_ovpos", 2'd0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1);

      // early-out: done already high right after the capture edge
      run0(2'd0, 32'h0, 32'h1234_5678, lat);
      chk("eo_lat", 64'(lat), 64'd0);
      chk("eo_out", 64'(if0.out), 64'd0);
      chk("eo_ov",  64'(if0.ov), 64'd0);
      release0();

      // same operands, no shortcut
      @(negedge clk);
      if1.mul_op = 2'd0; if1.in_a = 32'h0; if1.in_b = 32'h1234_5678; if1.enable = 1;
      @(posedge clk); #1;
      lat = 0;
      while (!if1.done && lat < 60) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("noeo_lat", 64'(lat), 64'd33);
      chk("noeo_out", 64'(if1.out), 64'd0);
      @(negedge clk); if1.enable = 0;

      // leave a known value, then cancel on BUSY edge 10
      op_chk("pre_cancel", 2'd3, 32'd100, 32'd3, 32'd300, 1'b0);
      @(negedge clk);
      if0.mul_op = 2'd0; if0.in_a = 32'd9; if0.in_b = 32'd9; if0.enable = 1;
      @(posedge clk);
      repeat (9) @(posedge clk);
      @(negedge clk); if0.enable = 0;
      seen = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (if0.done) seen = 1;
      end
      chk("cancel_done", 64'(seen), 64'd0);
      chk("cancel_out", 64'(if0.out), 64'd300);
      op_chk("lw_7x6", 2'd0, 32'd7, 32'd6, 32'h0000_002A, 1'b0);

      // hold enable in DONE for 5 cycles
      run0(2'd3, 32'd11, 32'd13, lat);
      held = if0.out;
      chk("hold_first", 64'(held), 64'd143);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk("hold_done", 64'(if0.done), 64'd1);
         chk("hold_out", 64'(if0.out), 64'd143);
      end
      release0();
      chk("drop_done", 64'(if0.done), 64'd0);
      chk("drop_out", 64'(if0.out), 64'd143);

      // async reset mid-BUSY, checked before the next clock edge
      @(negedge clk);
      if0.mul_op = 2'd3; if0.in_a = 32'd5; if0.in_b = 32'd5; if0.enable = 1;
      repeat (6) @(posedge clk);
      @(negedge clk); #2;
      reset_n = 0;
      #1;
      chk("arst_done", 64'(if0.done), 64'd0);
      chk("arst_out",  64'(if0.out), 64'd0);
      if0.enable = 0;
      @(negedge clk); reset_n = 1;
      repeat (2) @(posedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/execute_multiply.md
Name: execute_multiply

Overview:
- Iterative 32x32 integer multiplier for the execute stage; the inverse companion of the iterative divider.
- Handshake is identical to the divider: enable / done, cancellable, result held until the next request.
- Produces the low or high word of a signed or unsigned product, plus the overflow flag for mullwo.
- Execute stage instantiates it beside the divider and muxes `out`/`ov` by instruction class.

Parameters:
EARLY_OUT  1  when 1, a zero operand completes in 1 cycle; when 0, it takes the full iterative path.

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous, active-low reset
enable  in  1  request; held high until done is seen, and dropping it cancels the operation
mul_op  in  2  0=MULLW (signed, low word), 1=MULHW (signed, high word), 2=MULHWU (unsigned, high word), 3=MULLWU (unsigned, low word)
in_a  in  `REGSZ  multiplicand
in_b  in  `REGSZ  multiplier
done  out  1  result valid; equals (state==DONE)
out  out  `REGSZ  selected product word
ov  out  1  overflow, defined for MULLW only; 0 for all other ops

Behaviour:
- One clock domain (clk). reset_n low asynchronously forces state=IDLE, out=0, ov=0, done=0, regardless of current state.
- States: IDLE, BUSY, FIX, DONE.
- IDLE, enable=1 sampled at edge E0:
  - Latch mul_op.
  - Signed ops (0, 1): A=|in_a|, B=|in_b|, negate=in_a[31]^in_b[31]. |0x80000000| = 0x80000000, treated as a 32-bit unsigned magnitude.
  - Unsigned ops: A=in_a, B=in_b, negate=0.
  - P (64 bit) = 0, count=31, go to BUSY.
  - If EARLY_OUT and (in_a==0 or in_b==0): out=0, ov=0, go directly to DONE; done is high after E0.
- BUSY, one iteration per edge, LSB-first shift-add:
  - If B[0], P[63:32] += A, with the carry going into a 33-bit sum.
  - Then {carry, P} is shifted right by 1 and B is shifted right by 1.
  - count decrements; the edge where count==0 goes to FIX. That is 32 iterations, edges E1..E32.
- FIX, edge E33:
  - Apply the two's-complement negate to the 64-bit P if negate.
  - Select the word: ops 0 and 3 take P[31:0]; ops 1 and 2 take P[63:32].
  - ov = (op==0) and P_signed[63:31] not all equal. Other ops give ov=0.
  - Go to DONE; done is high after E33. Normal latency is 33 cycles after the capture edge.
- DONE:
  - Hold until enable=0, then go to IDLE on the next edge.
  - out/ov stay stable after leaving DONE, until the next accepted request writes them.
  - enable held high in DONE does not restart the operation.
- Cancel: enable=0 sampled in BUSY or FIX returns to IDLE with out/ov unchanged and done never asserted.
- Simultaneous events: asynchronous reset overrides everything. A new enable is accepted only in IDLE. Inputs are sampled only at E0 and may change afterwards.
- Widths: all 64-bit product arithmetic is modulo 2^64. Negation is of the full 64 bits, never of a word-selected half.

Decomposition:
- mul_op encodings (MUL_LW, MUL_HW, MUL_HWU, MUL_LWU) go in decode_enums.vh, next to the divide op codes.
- State encodings are local defines.
- No sub-module: one flat always block, plus an assign for done.

Test Plan:
- MULHWU, 0xFFFFFFFF x 0xFFFFFFFF -> out=0xFFFFFFFE, ov=0, done rises exactly 33 cycles after the capture edge.
- MULLW, 0x80000000 x 0xFFFFFFFF -> out=0x80000000, ov=1. MULHW with the same operands -> out=0x00000000, ov=0.
- Signed operands 0xFFFFFFFE x 0x00000003:
  - MULLW -> out=0xFFFFFFFA, ov=0.
  - MULHW -> out=0xFFFFFFFF.
  - MULHWU -> out=0x00000002.
- EARLY_OUT=1, in_a=0, in_b=0x12345678 -> done high one edge after capture, out=0, ov=0. EARLY_OUT=0 with the same operands -> done after 33 edges.
- Drop enable on BUSY edge 10 -> done never rises, out keeps its previous value. Then MULLW 7 x 6 -> out=0x0000002A.
- Hold enable for 5 cycles in DONE -> out stable, no restart, and done falls one edge after enable drops. Pull reset_n low mid-BUSY -> done=0 and out=0 immediately, without waiting for a clock edge.
